sr04_scan_scheduler: RTL and testbench
======================================

Name: sr04_scan_scheduler

Overview:
Sequences trigger/echo measurements for up to NUM_SENSORS HC-SR04 ultrasonic sensors that share one measurement engine. Sensors are serviced in round-robin order. The block enforces the datasheet inter-measurement gap, applies echo timeouts, and converts echo width to centimetres with an incremental divide-by-58 (no divider). It sits between the 1 MHz tick generator/button debounce and the FND/display or any result consumer.

Parameters:
NUM_SENSORS, 4, number of sensors scanned (1..8)
TRIG_US, 10, trigger pulse width in tick_1MHz periods
TIMEOUT_US, 25000, max wait for echo rise, and separately max echo high time
GAP_US, 60000, idle ticks between end of one measurement and next trigger
US_PER_CM, 58, echo microseconds per centimetre

Ports:
clk  input  1  system clock (100 MHz)
reset  input  1  asynchronous active-high reset
tick_1MHz  input  1  one-clk pulse every 1 us
start  input  1  one-clk pulse: run one full scan of all sensors
enable  input  1  level: continuous scanning while high
echo  input  NUM_SENSORS  echo lines, one per sensor
trigger  output  NUM_SENSORS  trigger lines, one-hot or zero
dist_data  output  12  distance in cm of the last completed measurement
dist_sel  output  3  sensor index of dist_data
dist_valid  output  1  one-clk pulse when dist_data/dist_sel update
timeout_err  output  1  qualifies dist_valid: measurement timed out
busy  output  1  high whenever state != IDLE

Behaviour:
- Clocking: one clock (clk). Reset is asynchronous and active-high. All state and outputs are registered.
- Reset values: trigger=0, dist_data=0, dist_sel=0, dist_valid=0, timeout_err=0, busy=0, FSM=IDLE, sensor index=0.
- Reset mid-operation forces trigger low immediately (asynchronous) and discards the measurement in progress.
- Time base: all us counters advance only on clk cycles where tick_1MHz=1. Edge detection on echo is evaluated every clk.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, REPORT, GAP.
- IDLE: on start=1 or enable=1, set idx=0 and go to TRIG. start while busy is ignored.
- TRIG: trigger[idx]=1 from the first clk in the state. After TRIG_US ticks, drop trigger and go to WAIT_RISE.
- WAIT_RISE: on echo[idx] rising, clear counters and go to MEASURE. If TIMEOUT_US ticks pass first, set the timeout flag and go to REPORT.
- MEASURE:
  - On each tick while echo high, increment sub-counter.
  - When sub-counter reaches US_PER_CM-1, wrap it to 0 and increment cm (saturate at 4095).
  - On echo falling edge, go to REPORT.
  - If echo stays high for TIMEOUT_US ticks, set the timeout flag and go to REPORT.
- REPORT (1 clk):
  - Registered outputs present dist_valid=1 on the cycle after REPORT, with dist_sel=idx.
  - dist_data=cm, or 12'hFFF on timeout. timeout_err=flag.
  - dist_data and dist_sel hold until the next report.
  - Then go to GAP.
- GAP: wait GAP_US ticks. Then, if idx<NUM_SENSORS-1, set idx=idx+1 and go to TRIG.
- Wrap-around at idx=NUM_SENSORS-1: if enable=1, set idx=0 and go to TRIG. Otherwise go to IDLE.
- enable falling mid-scan: the current scan completes through the last sensor, then the FSM returns to IDLE.
- Only one trigger bit is ever high at a time.
- Echo on non-selected sensors is ignored.
- The fractional remainder in the sub-counter is truncated, matching integer us/58.

Optional Feature:
SR04_ECHO_SYNC_EN:
- Defined: each echo bit passes through a 2-flop synchronizer before edge detection. This adds 2 clk latency to the rise and fall edges but does not change the cm result.
- Undefined: echo is sampled directly, with a single register used only for edge detection.

Test Plan:
- start pulse, NUM_SENSORS=4, sensor0 echo high 580 us -> trigger[0] high exactly 10 ticks; dist_valid with dist_sel=0, dist_data=10, timeout_err=0.
- Echo high 1739 us on sensor2 -> dist_data=29 (truncation), dist_sel=2; trigger[2] occurs >=60000 ticks after sensor1's report.
- Sensor1 never raises echo -> after 25000 ticks: dist_valid, dist_data=12'hFFF, timeout_err=1; scan continues to sensor2.
- enable=1 held, then enable dropped during sensor1 GAP -> sensors 2,3 still measured, then busy=0 and no further trigger; start during busy has no effect.
- Assert reset while trigger[3]=1 -> trigger=0 immediately with no clk edge; all outputs return to reset values; next start begins at sensor0.
- Echo toggled on non-selected sensor3 while measuring sensor0 (echo 2900 us) -> dist_data=50, dist_sel=0, no extra dist_valid.

Source files
------------

// File: rtl/sr04_scan_scheduler.sv
// Round-robin HC-SR04 scan scheduler: trigger, echo timing, divide-by-58 distance.
// Optional macro SR04_ECHO_SYNC_EN adds a 2-flop synchronizer on every echo line.
module sr04_scan_scheduler #(
    parameter int NUM_SENSORS = 4,
    parameter int TRIG_US     = 10,
    parameter int TIMEOUT_US  = 25000,
    parameter int GAP_US      = 60000,
    parameter int US_PER_CM   = 58
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick_1MHz,
    input  logic                   start,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] echo,
    output logic [NUM_SENSORS-1:0] trigger,
    output logic [11:0]            dist_data,
    output logic [2:0]             dist_sel,
    output logic                   dist_valid,
    output logic                   timeout_err,
    output logic                   busy
);

    localparam int CNT_MAX = (TIMEOUT_US > GAP_US)
                           ? ((TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US)
                           : ((GAP_US > TRIG_US) ? GAP_US : TRIG_US);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int SUB_W = $clog2(US_PER_CM + 1);

    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_US - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_US - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_US - 1);
    localparam logic [SUB_W-1:0] SUB_LAST     = SUB_W'(US_PER_CM - 1);
    localparam logic [2:0]       IDX_LAST     = 3'(NUM_SENSORS - 1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        REPORT,
        GAP
    } state_t;

    state_t                 state, state_n;
    logic [2:0]             idx, idx_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [SUB_W-1:0]       sub, sub_n;
    logic [11:0]            cm, cm_n;
    logic                   flag, flag_n;
    logic                   report;
    logic [NUM_SENSORS-1:0] trig_n;

    logic [NUM_SENSORS-1:0] echo_cur, echo_prev;
    logic                   echo_now, echo_was, echo_rise, echo_fall;

`ifdef SR04_ECHO_SYNC_EN
    logic [NUM_SENSORS-1:0] echo_s1, echo_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            echo_s1 <= '0;
            echo_s2 <= '0;
        end else begin
            echo_s1 <= echo;
            echo_s2 <= echo_s1;
        end
    end

    assign echo_cur = echo_s2;
`else
    assign echo_cur = echo;
`endif

    // Edge history is kept for all lines so a newly selected sensor that is
    // already high does not look like a fresh rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) echo_prev <= '0;
        else       echo_prev <= echo_cur;
    end

    always_comb begin
        echo_now = 1'b0;
        echo_was = 1'b0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (idx == 3'(i)) begin
                echo_now = echo_cur[i];
                echo_was = echo_prev[i];
            end
        end
    end

    assign echo_rise = echo_now & ~echo_was;
    assign echo_fall = ~echo_now & echo_was;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        sub_n   = sub;
        cm_n    = cm;
        flag_n  = flag;
        report  = 1'b0;

        unique case (state)
            IDLE: begin
                if (start || enable) begin
                    idx_n   = 3'd0;
                    cnt_n   = '0;
                    state_n = TRIG;
                end
            end
            TRIG: begin
                if (tick_1MHz) begin
                    if (cnt == TRIG_LAST) begin
                        cnt_n   = '0;
                        state_n = WAIT_RISE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            WAIT_RISE: begin
                if (echo_rise) begin
                    cnt_n   = '0;
                    sub_n   = '0;
                    cm_n    = '0;
                    state_n = MEASURE;
                end else if (tick_1MHz) begin
                    if (cnt == TIMEOUT_LAST) begin
                        flag_n  = 1'b1;
                        state_n = REPORT;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            MEASURE: begin
                if (echo_fall) begin
                    state_n = REPORT;
                end else if (tick_1MHz && echo_now) begin
                    // Incremental divide: every US_PER_CM ticks add one cm.
                    if (sub == SUB_LAST) begin
                        sub_n = '0;
                        if (cm != 12'hFFF) cm_n = cm + 1'b1;
                    end else begin
                        sub_n = sub + 1'b1;
                    end
                    if (cnt == TIMEOUT_LAST) begin
                        flag_n  = 1'b1;
                        state_n = REPORT;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            REPORT: begin
                report  = 1'b1;
                flag_n  = 1'b0;
                cnt_n   = '0;
                state_n = GAP;
            end
            GAP: begin
                if (tick_1MHz) begin
                    if (cnt == GAP_LAST) begin
                        cnt_n = '0;
                        if (idx != IDX_LAST) begin
                            idx_n   = idx + 1'b1;
                            state_n = TRIG;
                        end else if (enable) begin
                            idx_n   = 3'd0;
                            state_n = TRIG;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        trig_n = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            trig_n[i] = (state_n == TRIG) && (idx_n == 3'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= 3'd0;
            cnt         <= '0;
            sub         <= '0;
            cm          <= '0;
            flag        <= 1'b0;
            trigger     <= '0;
            dist_data   <= '0;
            dist_sel    <= 3'd0;
            dist_valid  <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            sub        <= sub_n;
            cm         <= cm_n;
            flag       <= flag_n;
            trigger    <= trig_n;
            busy       <= (state_n != IDLE);
            dist_valid <= report;
            if (report) begin
                dist_data   <= flag ? 12'hFFF : cm;
                dist_sel    <= idx;
                timeout_err <= flag;
            end
        end
    end

endmodule

// File: tb/tb_sr04_scan_scheduler.sv
// Scoreboard bench for sr04_scan_scheduler: randomized sensor echoes and tick gaps
// checked against an arithmetic model of the ranging rules.
module tb_sr04_scan_scheduler;

    localparam int N    = 4;
    localparam int TRIG = 10;
    localparam int TMO  = 3000;
    localparam int GAP  = 200;
    localparam int UPC  = 58;

    logic         clk = 1'b0;
    logic         reset;
    logic         tick_1MHz;
    logic         start;
    logic         enable;
    logic [N-1:0] echo;
    logic [N-1:0] trigger;
    logic [11:0]  dist_data;
    logic [2:0]   dist_sel;
    logic         dist_valid;
    logic         timeout_err;
    logic         busy;

    sr04_scan_scheduler #(
        .NUM_SENSORS(N),
        .TRIG_US    (TRIG),
        .TIMEOUT_US (TMO),
        .GAP_US     (GAP),
        .US_PER_CM  (UPC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_1MHz  (tick_1MHz),
        .start      (start),
        .enable     (enable),
        .echo       (echo),
        .trigger    (trigger),
        .dist_data  (dist_data),
        .dist_sel   (dist_sel),
        .dist_valid (dist_valid),
        .timeout_err(timeout_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sel;
        int data;
        int to;
    } exp_t;

    exp_t exp_q[$];
    int   plan_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_valid = 0;
    bit   noise_en = 1'b0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, req);
        end
    endtask

    // Distance is whole centimetres of the echo width; no echo or an over-long
    // echo reports the all-ones code with the timeout flag.
    function automatic exp_t model(input int sel, input int w);
        exp_t e;
        e.sel = sel;
        if (w < 0 || w >= TMO) begin
            e.data = 4095;
            e.to   = 1;
        end else begin
            e.data = (w / UPC > 4095) ? 4095 : w / UPC;
            e.to   = 0;
        end
        return e;
    endfunction

    // Sensor emulation: inputs change 1 time unit after the active edge.
    initial begin
        int cur, ms, phase, d, w, cnt, j;
        logic [N-1:0] prev_trig;
        cur = -1; ms = 0; phase = 0; d = 0; w = 0; cnt = 0;
        prev_trig = '0;
        echo = '0;
        tick_1MHz = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                phase = 0;
                cur = -1;
                echo = '0;
                tick_1MHz = 1'b0;
                prev_trig = '0;
            end else begin
                tick_1MHz = ($urandom_range(7) != 0);
                if (trigger != '0 && prev_trig == '0) begin
                    for (int i = 0; i < N; i++) if (trigger[i]) cur = i;
                    echo[cur] = 1'b0;
                end
                if (trigger == '0 && prev_trig != '0) begin
                    if (plan_q.size() > 0) w = plan_q.pop_front();
                    else w = ($urandom_range(9) == 0) ? -1 : int'($urandom_range(1500));
                    ms = cur;
                    exp_q.push_back(model(cur, w));
                    if (w >= 0) begin
                        phase = 1;
                        d = $urandom_range(40, 1);
                    end
                end
                prev_trig = trigger;
                if (phase == 1) begin
                    if (d == 0) begin
                        echo[ms] = 1'b1;
                        tick_1MHz = 1'b0;
                        phase = 2;
                        cnt = 0;
                    end else begin
                        d--;
                    end
                end else if (phase == 2) begin
                    if (cnt == w) begin
                        echo[ms] = 1'b0;
                        phase = 0;
                    end else if (tick_1MHz) begin
                        cnt++;
                    end
                end
                if (noise_en && $urandom_range(15) == 0) begin
                    j = $urandom_range(N - 1);
                    if (j != cur && !(phase != 0 && j == ms)) echo[j] = ~echo[j];
                end
            end
        end
    end

    // Monitor: scoreboard pops on dist_valid; trigger width and gap timing.
    initial begin
        int trig_ticks, gap_ticks;
        bit in_trig, gap_on;
        exp_t e;
        trig_ticks = 0; gap_ticks = 0; in_trig = 0; gap_on = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                trig_ticks = 0; in_trig = 0; gap_on = 0;
            end else begin
                chk("trigger_onehot", ($countones(trigger) <= 1) ? 1 : 0, 1);
                if (trigger != '0) begin
                    in_trig = 1;
                    if (tick_1MHz) trig_ticks++;
                end else if (in_trig) begin
                    chk("trigger_ticks", trig_ticks, TRIG);
                    in_trig = 0;
                    trig_ticks = 0;
                end
                if (!busy) gap_on = 0;
                if (gap_on && trigger != '0) begin
                    chk("gap_ticks", gap_ticks, GAP);
                    gap_on = 0;
                end else if (gap_on && tick_1MHz) begin
                    gap_ticks++;
                end
                if (dist_valid) begin
                    n_valid++;
                    gap_on = 1;
                    gap_ticks = tick_1MHz ? 1 : 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid got sel %0d data %0d expected no report",
                                 dist_sel, dist_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("dist_sel", int'(dist_sel), e.sel);
                        chk("dist_data", int'(dist_data), e.data);
                        chk("timeout_err", int'(timeout_err), e.to);
                    end
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        chk(nm, int'(done), 1);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_trigger"}, int'(trigger), 0);
        chk({nm, "_dist_data"}, int'(dist_data), 0);
        chk({nm, "_dist_sel"}, int'(dist_sel), 0);
        chk({nm, "_dist_valid"}, int'(dist_valid), 0);
        chk({nm, "_timeout_err"}, int'(timeout_err), 0);
        chk({nm, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        bit seen;
        int stray;
        reset = 1'b1;
        start = 1'b0;
        enable = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Directed scan: 580us, no echo, 1739us, 2900us with noise on others.
        noise_en = 1'b1;
        n_valid = 0;
        plan_q = '{580, -1, 1739, 2900};
        pulse_start();
        repeat (2000) @(negedge clk);
        pulse_start();
        wait_idle(40000, "scan1_idle");
        chk("scan1_reports", n_valid, 4);
        chk("scan1_queue_empty", exp_q.size(), 0);

        // Continuous scanning, enable dropped during sensor1's gap of scan 2.
        n_valid = 0;
        @(negedge clk) enable = 1'b1;
        seen = 0;
        for (int i = 0; i < 40000 && !seen; i++) begin
            @(negedge clk);
            if (n_valid >= 6) seen = 1;
        end
        chk("enable_reached_sensor1", int'(seen), 1);
        enable = 1'b0;
        wait_idle(30000, "enable_idle");
        chk("enable_reports", n_valid, 8);
        stray = 0;
        repeat (400) begin
            @(negedge clk);
            if (trigger != '0 || busy) stray++;
        end
        chk("no_trigger_after_enable", stray, 0);

        // Echo held past the timeout on sensor0, then reset while trigger[3] is high.
        n_valid = 0;
        plan_q = '{3050};
        pulse_start();
        seen = 0;
        for (int i = 0; i < 40000 && !seen; i++) begin
            @(negedge clk);
            if (trigger[3]) seen = 1;
        end
        chk("reached_trigger3", int'(seen), 1);
        chk("reports_before_reset", n_valid, 3);
        @(posedge clk);
        #3 reset = 1'b1;
        #1 chk("async_trigger_clear", int'(trigger), 0);
        exp_q.delete();
        plan_q.delete();
        @(negedge clk);
        check_reset_outputs("midrst");
        @(negedge clk) reset = 1'b0;
        n_valid = 0;
        repeat (3) @(negedge clk);
        pulse_start();
        wait_idle(30000, "post_reset_idle");
        chk("post_reset_reports", n_valid, 4);

        // Random scans.
        for (int k = 0; k < 2; k++) begin
            n_valid = 0;
            pulse_start();
            wait_idle(30000, "random_idle");
            chk("random_reports", n_valid, 4);
        end
        chk("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
